pipeline_flow_ctrl: RTL

//  Consumes Stall_data_hazard/Stall_ctrl_hazard from the ID-stage hazard detector and drives the

---
 rtl/pipeline_flow_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline freeze/bubble control: turns ID-stage hazard flags into PC/if2id/id2exe controls,
// tracks an outstanding branch until EXE resolves it, and keeps stall counters plus a timeout flag.
module pipeline_flow_ctrl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned BR_TIMEOUT = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Stall_data_hazard,
  input  logic             Stall_ctrl_hazard,
  input  logic             Branch_resolved,
  input  logic             Branch_taken,
  output logic             Pc_we,
  output logic             Pc_sel_branch,
  output logic             If2id_we,
  output logic             If2id_nop,
  output logic             Id2exe_nop,
  output logic [CNT_W-1:0] Data_stall_cnt,
  output logic [CNT_W-1:0] Ctrl_stall_cnt,
  output logic             Br_timeout_err
);

  localparam int unsigned WAIT_W = $clog2(BR_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [0:0] {RUN, BR_WAIT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              data_inc, ctrl_inc, err_set;

  // State, wait counter, saturating stall counters and sticky error
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q        <= RUN;
      wait_q         <= '0;
      Data_stall_cnt <= '0;
      Ctrl_stall_cnt <= '0;
      Br_timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (data_inc && (Data_stall_cnt != CNT_MAX))
        Data_stall_cnt <= Data_stall_cnt + CNT_W'(1);
      if (ctrl_inc && (Ctrl_stall_cnt != CNT_MAX))
        Ctrl_stall_cnt <= Ctrl_stall_cnt + CNT_W'(1);
      if (err_set)
        Br_timeout_err <= 1'b1;
    end
  end

  // Next state and Mealy controls; defaults are the NOP-flush values used during reset
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    Pc_we         = 1'b0;
    Pc_sel_branch = 1'b0;
    If2id_we      = 1'b1;
    If2id_nop     = 1'b1;
    Id2exe_nop    = 1'b1;
    data_inc      = 1'b0;
    ctrl_inc      = 1'b0;
    err_set       = 1'b0;

    if (Reset_n) begin
      case (state_q)
        RUN: begin
          if (Stall_data_hazard) begin
            If2id_we  = 1'b0;
            If2id_nop = 1'b0;
            data_inc  = 1'b1;
          end else if (Stall_ctrl_hazard) begin
            Id2exe_nop = 1'b0;
            state_d    = BR_WAIT;
            wait_d     = '0;
            ctrl_inc   = 1'b1;
          end else begin
            Pc_we      = 1'b1;
            If2id_nop  = 1'b0;
            Id2exe_nop = 1'b0;
          end
        end
        BR_WAIT: begin
          ctrl_inc = 1'b1;
          if (Branch_resolved) begin
            Pc_we         = 1'b1;
            Pc_sel_branch = Branch_taken;
            state_d       = RUN;
          end else if (wait_q == WAIT_LAST) begin
            // Give up on the branch and fall through to PC+4
            Pc_we   = 1'b1;
            err_set = 1'b1;
            state_d = RUN;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

endmodule
